hmm_diag_feeder: RTL and testbench

Input-side feeder for the PairHMM diagonal processing array (`new_HMM`). It buffers one read (bases and qualities) and one haplotype written by the host. On `start` it drives the array one anti-diagonal per handshake: it broadcasts the read bases and qualities to the PEs in parallel, and shifts the haplotype stream in with an active-PE mask. It is the producer end of the array's diagonal input port, and sits between host/testbench loading and `new_HMM`.

---
 rtl/hmm_pkg.sv | 25 ++
 rtl/hmm_diag_mask.sv | 26 ++
 rtl/hmm_diag_feeder.sv | 177 +++++++++++++++++
 tb/tb_hmm_diag_feeder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmm_pkg.sv
// Shared PairHMM definitions: base encodings, array sizing defaults, feeder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hmm_pkg;

  localparam int NPE_DEF    = 8;   // PEs in the diagonal array, also max read length
  localparam int MAX_H_DEF  = 64;  // max haplotype length
  localparam int BASE_W_DEF = 3;   // base code width
  localparam int QUAL_W_DEF = 6;   // Phred quality width

  typedef enum logic [2:0] {
    BASE_A = 3'd0,
    BASE_C = 3'd1,
    BASE_G = 3'd2,
    BASE_T = 3'd3,
    BASE_N = 3'd4
  } base_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feed_state_e;

endpackage

// File: rtl/hmm_diag_mask.sv
// Active-PE mask for anti-diagonal d: PE i holds cell (i, d-i) when that cell is inside the matrix.
// Latency: combinational.
// Backpressure: none; pure function of (d, rd_len, hap_len).
// Ports: d = diagonal index, rd_len/hap_len = run lengths, mask = one bit per PE.
module hmm_diag_mask
  import hmm_pkg::*;
#(
  parameter int NPE  = NPE_DEF,
  parameter int DG_W = 7,
  parameter int RL_W = 4,
  parameter int HL_W = 7
) (
  input  logic [DG_W-1:0] d,
  input  logic [RL_W-1:0] rd_len,
  input  logic [HL_W-1:0] hap_len,
  output logic [NPE-1:0]  mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NPE; i++) begin
      mask[i] = (i < int'(rd_len)) && (i <= int'(d)) && ((int'(d) - i) < int'(hap_len));
    end
  end

endmodule

// File: rtl/hmm_diag_feeder.sv
// Buffers one read and one haplotype, then streams one anti-diagonal word per handshake to new_HMM.
// Latency: start -> first out_valid 1 cycle; 1 diagonal/cycle with out_ready high; done 1 cycle after last accept.
// Backpressure: word held stable while out_valid && !out_ready; abort drops out_valid immediately.
// Ports: wr_* load buffers in IDLE; rd_len/hap_len/start launch a run; pe_rd_*/hap_base/pe_mask/diag_*
//        form the diagonal word qualified by out_valid/out_ready; busy/err/done report status.
module hmm_diag_feeder
  import hmm_pkg::*;
#(
  parameter int NPE    = NPE_DEF,
  parameter int MAX_H  = MAX_H_DEF,
  parameter int BASE_W = BASE_W_DEF,
  parameter int QUAL_W = QUAL_W_DEF,
  parameter int HA_W   = $clog2(MAX_H),
  parameter int DG_W   = $clog2(NPE + MAX_H),
  parameter int RL_W   = $clog2(NPE) + 1,
  parameter int HL_W   = HA_W + 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [HA_W-1:0]          wr_addr,
  input  logic [BASE_W-1:0]        wr_base,
  input  logic [QUAL_W-1:0]        wr_qual,
  input  logic [RL_W-1:0]          rd_len,
  input  logic [HL_W-1:0]          hap_len,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     err,
  output logic                     done,
  output logic [NPE*BASE_W-1:0]    pe_rd_base,
  output logic [NPE*QUAL_W-1:0]    pe_rd_qual,
  output logic [BASE_W-1:0]        hap_base,
  output logic [NPE-1:0]           pe_mask,
  output logic [DG_W-1:0]          diag_idx,
  output logic                     diag_first,
  output logic                     diag_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int RA_W = $clog2(NPE);

  feed_state_e state, state_nxt;

  // Host-loaded buffers; contents survive abort and reset.
  logic [BASE_W-1:0] rd_base_mem [NPE];
  logic [QUAL_W-1:0] rd_qual_mem [NPE];
  logic [BASE_W-1:0] hap_mem     [MAX_H];

  logic [RL_W-1:0]   rl_q, rl_nxt;
  logic [HL_W-1:0]   hl_q, hl_nxt;
  logic [DG_W-1:0]   d_nxt;
  logic              load, upd, err_nxt, len_ok, last_nxt;
  logic [NPE-1:0]    mask_nxt;
  logic [BASE_W-1:0] hap_base_nxt;

  always_ff @(posedge sys_clk) begin
    if (state == ST_IDLE && wr_en) begin
      if (!wr_sel) begin
        if (int'(wr_addr) < NPE) begin
          rd_base_mem[wr_addr[RA_W-1:0]] <= wr_base;
          rd_qual_mem[wr_addr[RA_W-1:0]] <= wr_qual;
        end
      end else begin
        hap_mem[wr_addr] <= wr_base;
      end
    end
  end

  assign len_ok = (rd_len != '0) && (int'(rd_len) <= NPE) &&
                  (hap_len != '0) && (int'(hap_len) <= MAX_H);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state plus the next diagonal/lengths; the word registers below sample these
  // so every output stays a flop.
  always_comb begin
    state_nxt = state;
    d_nxt     = diag_idx;
    rl_nxt    = rl_q;
    hl_nxt    = hl_q;
    load      = 1'b0;
    upd       = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_nxt = ST_RUN;
            d_nxt     = '0;
            rl_nxt    = rd_len;
            hl_nxt    = hap_len;
            load      = 1'b1;
            upd       = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // abort beats a coinciding transfer: nothing advances
        if (out_ready && !abort) begin
          if (diag_last) begin
            state_nxt = ST_DONE;
          end else begin
            d_nxt = diag_idx + 1'b1;
            upd   = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  hmm_diag_mask #(
    .NPE  (NPE),
    .DG_W (DG_W),
    .RL_W (RL_W),
    .HL_W (HL_W)
  ) u_mask (
    .d       (d_nxt),
    .rd_len  (rl_nxt),
    .hap_len (hl_nxt),
    .mask    (mask_nxt)
  );

  // Past the haplotype end the stream into PE0 is padded with 0.
  assign hap_base_nxt = (int'(d_nxt) < int'(hl_nxt)) ? hap_mem[d_nxt[HA_W-1:0]] : '0;
  assign last_nxt     = (int'(d_nxt) == int'(rl_nxt) + int'(hl_nxt) - 2);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy       <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      diag_idx   <= '0;
      diag_first <= 1'b0;
      diag_last  <= 1'b0;
      hap_base   <= '0;
      pe_mask    <= '0;
      pe_rd_base <= '0;
      pe_rd_qual <= '0;
      rl_q       <= '0;
      hl_q       <= '0;
    end else begin
      busy      <= (state_nxt != ST_IDLE);
      out_valid <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
      err       <= err_nxt;
      // Word fields only move on launch or accepted transfer, so they hold through stalls.
      if (upd) begin
        diag_idx   <= d_nxt;
        diag_first <= (d_nxt == '0);
        diag_last  <= last_nxt;
        hap_base   <= hap_base_nxt;
        pe_mask    <= mask_nxt;
      end
      if (load) begin
        rl_q <= rd_len;
        hl_q <= hap_len;
        for (int i = 0; i < NPE; i++) begin
          pe_rd_base[i*BASE_W +: BASE_W] <= (i < int'(rd_len)) ? rd_base_mem[i] : '0;
          pe_rd_qual[i*QUAL_W +: QUAL_W] <= (i < int'(rd_len)) ? rd_qual_mem[i] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hmm_diag_feeder.sv
module tb_hmm_diag_feeder;
  import hmm_pkg::*;

  localparam int NPE = 8, MAX_H = 64, BASE_W = 3, QUAL_W = 6;
  localparam int HA_W = 6, DG_W = 7, RL_W = 4, HL_W = 7;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst = 1'b1;
  logic                  wr_en = 1'b0, wr_sel = 1'b0;
  logic [HA_W-1:0]       wr_addr = '0;
  logic [BASE_W-1:0]     wr_base = '0;
  logic [QUAL_W-1:0]     wr_qual = '0;
  logic [RL_W-1:0]       rd_len = '0;
  logic [HL_W-1:0]       hap_len = '0;
  logic                  start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic                  busy, err, done, diag_first, diag_last, out_valid;
  logic [NPE*BASE_W-1:0] pe_rd_base;
  logic [NPE*QUAL_W-1:0] pe_rd_qual;
  logic [BASE_W-1:0]     hap_base;
  logic [NPE-1:0]        pe_mask;
  logic [DG_W-1:0]       diag_idx;

  always #5 sys_clk = ~sys_clk;

  hmm_diag_feeder dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_base(wr_base), .wr_qual(wr_qual), .rd_len(rd_len), .hap_len(hap_len), .start(start),
    .abort(abort), .busy(busy), .err(err), .done(done), .pe_rd_base(pe_rd_base),
    .pe_rd_qual(pe_rd_qual), .hap_base(hap_base), .pe_mask(pe_mask), .diag_idx(diag_idx),
    .diag_first(diag_first), .diag_last(diag_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- reference model ----------------
  int tests = 0, fails = 0;
  bit m_run, m_done, m_err;
  int m_d, m_rl, m_hl;
  logic [BASE_W-1:0] mb_base [NPE];
  logic [QUAL_W-1:0] mb_qual [NPE];
  logic [BASE_W-1:0] mb_hap  [MAX_H];
  logic [NPE*BASE_W-1:0] m_lat_base;
  logic [NPE*QUAL_W-1:0] m_lat_qual;
  int acc_hb[$], acc_mask[$];
  int n_done = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PE i works on matrix column j = d - i; it is active when that cell exists.
  function automatic logic [NPE-1:0] m_mask(input int d, input int rl, input int hl);
    logic [NPE-1:0] m;
    int j;
    m = '0;
    for (int i = 0; i < rl; i++) begin
      j = d - i;
      if (j >= 0 && j < hl) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic m_reset();
    m_run = 0; m_done = 0; m_err = 0; m_d = 0; m_rl = 0; m_hl = 0;
  endtask

  // Compare DUT against model, then advance the model with the inputs the next edge will see.
  task automatic monitor();
    bit idle;
    chk("out_valid", 64'(out_valid), 64'(m_run));
    chk("busy", 64'(busy), 64'(m_run || m_done));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    if (done) n_done++;
    if (err) n_err++;
    if (m_run) begin
      chk("diag_idx", 64'(diag_idx), 64'(m_d));
      chk("hap_base", 64'(hap_base), (m_d < m_hl) ? 64'(mb_hap[m_d]) : 64'd0);
      chk("pe_mask", 64'(pe_mask), 64'(m_mask(m_d, m_rl, m_hl)));
      chk("diag_first", 64'(diag_first), 64'(m_d == 0));
      chk("diag_last", 64'(diag_last), 64'(m_d == m_rl + m_hl - 2));
      chk("pe_rd_base", 64'(pe_rd_base), 64'(m_lat_base));
      chk("pe_rd_qual", 64'(pe_rd_qual), 64'(m_lat_qual));
    end
    idle  = !m_run && !m_done;
    m_err = 0;
    if (sys_rst) begin
      m_reset();
      return;
    end
    if (abort) begin
      m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (out_ready) begin
        acc_hb.push_back(int'(hap_base));
        acc_mask.push_back(int'(pe_mask));
        if (m_d == m_rl + m_hl - 2) begin m_run = 0; m_done = 1; end
        else m_d++;
      end
    end else if (start) begin
      if (rd_len >= 1 && rd_len <= NPE && hap_len >= 1 && hap_len <= MAX_H) begin
        m_run = 1; m_d = 0; m_rl = int'(rd_len); m_hl = int'(hap_len);
        for (int i = 0; i < NPE; i++) begin
          m_lat_base[i*BASE_W +: BASE_W] = (i < m_rl) ? mb_base[i] : '0;
          m_lat_qual[i*QUAL_W +: QUAL_W] = (i < m_rl) ? mb_qual[i] : '0;
        end
      end else m_err = 1;
    end
    if (idle && wr_en) begin
      if (wr_sel) mb_hap[wr_addr] = wr_base;
      else if (wr_addr < NPE) begin
        mb_base[wr_addr[2:0]] = wr_base;
        mb_qual[wr_addr[2:0]] = wr_qual;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge sys_clk);
    monitor();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int sel, input int addr, input int b, input int q);
    wr_en = 1'b1; wr_sel = sel[0]; wr_addr = HA_W'(addr); wr_base = BASE_W'(b); wr_qual = QUAL_W'(q);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input int rl, input int hl);
    rd_len = RL_W'(rl); hap_len = HL_W'(hl); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready
  task automatic drain(input int mode, input int limit);
    int k;
    k = 0;
    while ((m_run || m_done) && k < limit) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      tick();
      k++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", 64'(m_run || m_done), 64'd0);
  endtask

  task automatic load_acgt();
    wr(0, 0, int'(BASE_A), 30); wr(0, 1, int'(BASE_C), 31);
    wr(0, 2, int'(BASE_G), 32); wr(0, 3, int'(BASE_T), 33);
    wr(1, 0, int'(BASE_A), 0);  wr(1, 1, int'(BASE_C), 0); wr(1, 2, int'(BASE_G), 0);
  endtask

  // Hand-derived words for read ACGT x haplotype ACG.
  task automatic check_acgt(input int base, input string tag);
    int hb[6];
    int mk[6];
    hb = '{0, 1, 2, 0, 0, 0};
    mk = '{8'h01, 8'h03, 8'h07, 8'h0e, 8'h0c, 8'h08};
    chk({tag, "_count"}, 64'(acc_hb.size() - base), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < acc_hb.size()) begin
        chk({tag, "_hb"}, 64'(acc_hb[base+k]), 64'(hb[k]));
        chk({tag, "_mask"}, 64'(acc_mask[base+k]), 64'(mk[k]));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, err, done, out_valid, diag_first, diag_last}), 64'd0);
    chk({tag, "_word"}, 64'({diag_idx, hap_base, pe_mask}), 64'd0);
    chk({tag, "_rd_base"}, 64'(pe_rd_base), 64'd0);
    chk({tag, "_rd_qual"}, 64'(pe_rd_qual), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nd, ne, rl, hl;
    m_reset();
    #1 chk_zero("por");
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();

    // basic run
    load_acgt();
    base = acc_hb.size(); nd = n_done;
    go(4, 3);
    drain(0, 50);
    check_acgt(base, "run1");
    chk("run1_done_cnt", 64'(n_done - nd), 64'd1);

    // stalled run
    base = acc_hb.size(); nd = n_done;
    go(4, 3);
    drain(1, 100);
    check_acgt(base, "stall");
    chk("stall_done_cnt", 64'(n_done - nd), 64'd1);

    // illegal lengths
    ne = n_err;
    go(0, 4); go(9, 4); go(4, 0); go(4, 65);
    tick();
    chk("err_cnt", 64'(n_err - ne), 64'd4);

    // maximum sizes
    for (int i = 0; i < NPE; i++) wr(0, i, $urandom_range(4), $urandom_range(63));
    for (int i = 0; i < MAX_H; i++) wr(1, i, $urandom_range(4), 0);
    base = acc_hb.size();
    go(NPE, MAX_H);
    drain(0, 200);
    chk("full_count", 64'(acc_hb.size() - base), 64'd71);
    chk("full_last_mask", 64'(acc_mask[acc_mask.size()-1]), 64'h80);
    chk("full_idx_hold", 64'(diag_idx), 64'd70);

    // abort at d=2, then replay
    load_acgt();
    nd = n_done;
    go(4, 3);
    tick(); tick();
    chk("abort_d", 64'(diag_idx), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    tick(); tick();
    chk("abort_no_done", 64'(n_done - nd), 64'd0);
    base = acc_hb.size();
    go(4, 3);
    drain(0, 50);
    check_acgt(base, "replay");

    // writes during RUN are ignored; reset at d=3
    go(4, 3);
    wr(1, 0, int'(BASE_T), 0);
    wr(0, 1, int'(BASE_N), 5);
    tick();
    chk("rst_d", 64'(diag_idx), 64'd3);
    sys_rst = 1'b1;
    m_reset();
    #1 chk_zero("midrun");
    tick();
    sys_rst = 1'b0;
    tick();
    base = acc_hb.size();
    go(4, 3);
    drain(0, 50);
    check_acgt(base, "post_rst");

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(3)) wr($urandom_range(1), $urandom_range(63), $urandom_range(4), $urandom_range(63));
      rl = $urandom_range(8);
      hl = $urandom_range(1, 24);
      go(rl, hl);
      if (rl != 0 && $urandom_range(4) == 0) begin
        repeat ($urandom_range(1, 5)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      drain(2, 400);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
